// File: rtl/f_ifu_npc.sv
// Fetch stage: program counter, next-PC selection (branch/jump/jr with delay slot) and F/D pipeline register.
// Optional F_PC_ALIGN_CHK_EN adds D_adel and squashes instructions fetched from a bad address.
module f_ifu_npc (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic [31:0] F_instr,
  input  logic [2:0]  npc_op,
  input  logic        D_cmp_zero,
  input  logic [31:0] D_jr_target,
  output logic [31:0] F_pc,
  output logic [31:0] D_pc,
  output logic [31:0] D_instr,
  output logic        D_valid,
  output logic [31:0] D_pc8
`ifdef F_PC_ALIGN_CHK_EN
  ,
  output logic        D_adel
`endif
);

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] IM_LO    = 32'h0000_3000;
  localparam logic [31:0] IM_HI    = 32'h0000_6FFF;

  typedef enum logic {BOOT, RUN} state_e;

  state_e      state_q;
  logic [31:0] pc_q;
  logic [31:0] d_pc_q;
  logic [31:0] d_instr_q;
  logic        d_valid_q;

  logic [31:0] npc_d;
  logic [31:0] instr_d;
  logic [31:0] pc_plus4;
  logic [31:0] d_pc_plus4;
  logic [31:0] br_target;
  logic [31:0] j_target;
  logic [15:0] imm16;
  logic [25:0] index26;
  logic        redirect_en;

  assign imm16      = d_instr_q[15:0];
  assign index26    = d_instr_q[25:0];
  assign pc_plus4   = pc_q + 32'd4;
  assign d_pc_plus4 = d_pc_q + 32'd4;
  assign br_target  = d_pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
  assign j_target   = {d_pc_plus4[31:28], index26, 2'b00};

  // A bubble in D (BOOT) must never redirect fetch, whatever npc_op says.
  assign redirect_en = (state_q == RUN) && d_valid_q;

  always_comb begin
    npc_d = pc_plus4;
    if (redirect_en) begin
      case (npc_op)
        3'd1: if (D_cmp_zero) npc_d = br_target;
        3'd2: npc_d = j_target;
        3'd3: npc_d = D_jr_target;
        default: npc_d = pc_plus4;
      endcase
    end
  end

`ifdef F_PC_ALIGN_CHK_EN
  logic adel_d;
  logic adel_q;

  assign adel_d  = (pc_q[1:0] != 2'b00) || (pc_q < IM_LO) || (pc_q > IM_HI);
  assign instr_d = adel_d ? 32'h0 : F_instr;
  assign D_adel  = adel_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)    adel_q <= 1'b0;
    else if (!stall) adel_q <= adel_d;
  end
`else
  assign instr_d = F_instr;
`endif

  // Stall freezes everything, so a pending redirect is simply re-evaluated next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      d_pc_q    <= 32'h0;
      d_instr_q <= 32'h0;
      d_valid_q <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        BOOT:    state_q <= RUN;
        default: state_q <= RUN;
      endcase
      pc_q      <= npc_d;
      d_pc_q    <= pc_q;
      d_instr_q <= instr_d;
      d_valid_q <= 1'b1;
    end
  end

  assign F_pc    = pc_q;
  assign D_pc    = d_pc_q;
  assign D_instr = d_instr_q;
  assign D_valid = d_valid_q;
  assign D_pc8   = d_pc_q + 32'd8;

endmodule

// File: doc/f_ifu_npc.md
F_IFU_NPC -- requirements
Module: f_ifu_npc

Interface
REQ-001 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port stall  input  1  hazard-unit freeze of PC and F/D register.
REQ-004 SHALL have port F_instr  input  32  instruction word returned by IM for F_pc, same cycle.
REQ-005 SHALL have port npc_op  input  3  D-stage next-PC select: 0 PC+4, 1 branch, 2 j/jal, 3 jr; 4-7 treated as 0.
REQ-006 SHALL have port D_cmp_zero  input  1  branch-taken flag from D-stage comparator.
REQ-007 SHALL have port D_jr_target  input  32  forwarded rs value for jr.
REQ-008 SHALL have port F_pc  output  32  current fetch address to IM.
REQ-009 SHALL have port D_pc  output  32  PC of instruction held in D.
REQ-010 SHALL have port D_instr  output  32  instruction held in D.
REQ-011 SHALL have port D_valid  output  1  D holds a real fetched instruction.
REQ-012 SHALL have port D_pc8  output  32  D_pc+8, link value for jal.

Function
REQ-013 SHALL decode imm16 = D_instr[15:0] and index26 = D_instr[25:0] internally; no extra immediate ports.
REQ-014 SHALL compute branch target = D_pc + 4 + (sign-extended imm16 << 2), 32-bit modulo.
REQ-015 SHALL compute jump target = {D_pc_plus4[31:28], index26, 2'b00}.
REQ-016 SHALL select next PC: npc_op 1 and D_cmp_zero=1 -> branch target; npc_op 1 and D_cmp_zero=0 -> F_pc+4; 2 -> jump target; 3 -> D_jr_target; else F_pc+4.
REQ-017 SHALL ignore npc_op when D_valid=0 (next PC = F_pc+4).
REQ-018 SHALL implement architectural delay slot: redirect applies to PC after F_pc; instruction already in F enters D unchanged.
REQ-019 SHALL, when stall=0, load PC <= next PC, D_instr <= F_instr, D_pc <= F_pc, D_valid <= 1 on the same edge.
REQ-020 SHALL, when stall=1, hold PC, D_instr, D_pc, D_valid; redirect is re-evaluated next cycle from frozen D state (stall wins over redirect).
REQ-021 SHALL wrap F_pc+4 modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-022 SHALL implement 2-state FSM: BOOT (after reset, D_valid=0) -> RUN on first edge with stall=0; RUN persists until reset; stall in BOOT keeps BOOT.
REQ-023 SHALL have one-cycle latency F -> D; F_pc changes only on clock edges or reset.

Reset
REQ-024 SHALL on reset_n=0, independent of clk, force F_pc=0x00003000, D_pc=0x00000000, D_instr=0x00000000, D_valid=0, FSM=BOOT.
REQ-025 SHALL, on reset mid-stall or mid-redirect, discard the pending redirect; fetch resumes at 0x00003000.
REQ-026 SHALL drive D_pc8 = D_pc+8 combinationally (0x00000008 during reset).

Configuration
REQ-027 SHALL, with macro F_PC_ALIGN_CHK_EN defined, add output D_adel (1 bit) registered with D, set when latched F_pc[1:0]!=0 or F_pc outside 0x00003000-0x00006FFF, and load D_instr=0 instead of F_instr in that case.
REQ-028 SHALL, without F_PC_ALIGN_CHK_EN, omit D_adel entirely and pass F_instr unconditionally.

Verification
REQ-029 SHALL verify reset: reset_n low mid-run -> F_pc=0x00003000, D_valid=0, D_instr=0 immediately; first edge after release -> D_pc=0x00003000, F_pc=0x00003004.
REQ-030 SHALL verify taken beq: D_pc=0x00003008, imm16=0xFFFE, npc_op=1, D_cmp_zero=1 -> next F_pc=0x00003004 after delay slot at 0x0000300C enters D.
REQ-031 SHALL verify not-taken branch: same stimulus with D_cmp_zero=0 -> F_pc advances 0x0000300C -> 0x00003010.
REQ-032 SHALL verify stall with redirect: stall=1 for 3 cycles with npc_op=3, D_jr_target=0x00004000 -> F_pc, D_pc held; stall drop -> F_pc=0x00004000.
REQ-033 SHALL verify jump: D_pc=0x00003010, index26=0x0000C10 -> F_pc=0x00003040.
REQ-034 SHALL verify, with F_PC_ALIGN_CHK_EN, jr to 0x00003002 -> next D_adel=1, D_instr=0; without macro, D_instr=F_instr.
